cplx_mac_pipe: RTL and testbench
================================

Name: cplx_mac_pipe

Overview:
- Parametrised, pipelined successor to the team's 8x8 complex multiplier.
- Computes signed complex products A*B or A*conj(B) at full throughput with a valid/ready handshake.
- Optionally accumulates a programmable number of products per frame before emitting one result.
- Sits between sample sources and downstream correlation/filter stages in the complex datapath.

Parameters:
- N, 8, operand width per real/imag component; signed two's complement.
- CW, 4, frame-count width. Frame length is 1..2^CW products.
- OW, 2*N+1+CW, output component width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- a_re, a_im  in  N  operand A (signed)
- b_re, b_im  in  N  operand B (signed)
- conj_b  in  1  1: use conj(B); sampled with each input beat
- acc_len  in  CW  products per frame; 0 encodes 2^CW; sampled on the first beat of each frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_re, out_im  out  OW  signed result

Behaviour:
- Reset: rst high asynchronously clears all stage valids, the accumulator, the frame counter and the latched length. Outputs are out_valid=0, out_re=0, out_im=0, in_ready=1. A partial frame is discarded.
- Advance signal: adv = !out_valid || out_ready. in_ready = adv. The whole pipeline moves only when adv=1; otherwise every stage holds, with no bubbles lost or duplicated.
- Accept: a beat is accepted when in_valid && in_ready.
- S1 (accept edge): register operands, conj_b, and a valid bit v1.
- S2: four signed products, each 2N bits:
  - p0 = a_re*b_re, p1 = a_im*b_im, p2 = a_re*b_im, p3 = a_im*b_re.
  - Register p0..p3 with v2.
- S3, sign-extend all terms to OW:
  - conj_b=0: re = p0 - p1, im = p2 + p3.
  - conj_b=1: re = p0 + p1, im = p3 - p2.
- Frame counter: cnt counts products in the current frame. len is latched from acc_len when cnt==0 and the beat is accepted.
- On v2 && adv:
  - If cnt+1 == len: out_re <= acc_re + re, out_im <= acc_im + im, out_valid <= 1, acc <= 0, cnt <= 0.
  - Else: acc <= acc + term, cnt <= cnt+1, and out_valid <= 0 if the output handshake completes that cycle.
- Output hold: if out_valid && !out_ready, out_re, out_im and out_valid hold stable.
- Latency: an accepted beat at edge t produces out_valid at edge t+3 when len=1. With len=L, the result appears 3 edges after the L-th beat. Throughput is one beat per cycle with out_ready=1.
- Overflow: none possible. OW holds 2^CW sums of the worst case (-2^(N-1))^2*2.
- Mid-frame length: acc_len changes mid-frame are ignored until the next frame.
- conj_b: may change every beat, mixed within a frame.
- Simultaneous completion: when a frame completes in the same cycle the old result handshakes, the new result replaces it and out_valid stays 1.

Test Plan:
- Basic product, N=8, acc_len=1, conj_b=0: A=3+4j, B=5+6j -> out_valid at cycle 3 after accept, out = -9+38j.
- Conjugate, same operands with conj_b=1 -> out = 39+2j.
- Extremes: A=B=-128-128j, conj_b=0 -> out = 0+32768j with no wrap. Same operands with conj_b=1 -> out = 32768+0j.
- Accumulate, acc_len=4: four beats of (1+1j)*(1+0j) back to back -> exactly one out_valid pulse, out = 4+4j. Then a new frame with acc_len=1 produces per-beat results.
- Backpressure: stream 6 beats, acc_len=1, with out_ready low for 5 cycles mid-stream:
  - in_ready drops in the same cycle;
  - out_re/out_im are held;
  - all 6 results arrive in order with none lost or duplicated.
- Reset mid-frame: acc_len=4, 2 beats accepted, assert rst for 1 cycle:
  - outputs immediately become 0 with out_valid=0;
  - the next 4 beats of 2+0j * 1+0j -> out = 8+0j (no residue from the aborted frame).

Source files
------------

// File: rtl/cplx_mac_pipe.sv
// Pipelined signed complex multiply (A*B or A*conj(B)) with per-frame accumulation.
// Three register stages (operands, partial products, combined terms) feed the accumulator/output register.
module cplx_mac_pipe #(
    parameter int N  = 8,
    parameter int CW = 4,
    parameter int OW = 2*N+1+CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [N-1:0]  a_re,
    input  logic signed [N-1:0]  a_im,
    input  logic signed [N-1:0]  b_re,
    input  logic signed [N-1:0]  b_im,
    input  logic                 conj_b,
    input  logic [CW-1:0]        acc_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im
);

    logic adv;
    logic accept;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Frame position is tracked at the input so the latched length never
    // races beats still in flight; the end of frame travels down as a tag.
    logic [CW-1:0] in_cnt_reg;
    logic [CW-1:0] len_reg;
    logic [CW-1:0] len_eff;
    logic [CW:0]   len_full;
    logic          last_beat;

    always_comb begin
        len_eff   = (in_cnt_reg == '0) ? acc_len : len_reg;
        len_full  = (len_eff == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, len_eff};
        last_beat = (({1'b0, in_cnt_reg} + (CW+1)'(1)) == len_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_reg <= '0;
            len_reg    <= '0;
        end else if (accept) begin
            if (in_cnt_reg == '0)
                len_reg <= acc_len;
            in_cnt_reg <= last_beat ? '0 : in_cnt_reg + 1'b1;
        end
    end

    // Stage 1: operand capture
    logic                v1_reg, last1_reg, conj1_reg;
    logic signed [N-1:0] a_re1_reg, a_im1_reg, b_re1_reg, b_im1_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            last1_reg <= 1'b0;
            conj1_reg <= 1'b0;
            a_re1_reg <= '0;
            a_im1_reg <= '0;
            b_re1_reg <= '0;
            b_im1_reg <= '0;
        end else if (adv) begin
            v1_reg    <= in_valid;
            last1_reg <= in_valid && last_beat;
            if (in_valid) begin
                conj1_reg <= conj_b;
                a_re1_reg <= a_re;
                a_im1_reg <= a_im;
                b_re1_reg <= b_re;
                b_im1_reg <= b_im;
            end
        end
    end

    // Stage 2: p0=a_re*b_re, p1=a_im*b_im, p2=a_re*b_im, p3=a_im*b_re
    logic signed [N-1:0]   mul_x [4];
    logic signed [N-1:0]   mul_y [4];
    logic signed [2*N-1:0] prod_reg [4];
    logic                  v2_reg, last2_reg, conj2_reg;

    assign mul_x[0] = a_re1_reg;
    assign mul_y[0] = b_re1_reg;
    assign mul_x[1] = a_im1_reg;
    assign mul_y[1] = b_im1_reg;
    assign mul_x[2] = a_re1_reg;
    assign mul_y[2] = b_im1_reg;
    assign mul_x[3] = a_im1_reg;
    assign mul_y[3] = b_re1_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mul
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    prod_reg[gi] <= '0;
                else if (adv)
                    prod_reg[gi] <= (2*N)'(mul_x[gi]) * (2*N)'(mul_y[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            last2_reg <= 1'b0;
            conj2_reg <= 1'b0;
        end else if (adv) begin
            v2_reg    <= v1_reg;
            last2_reg <= last1_reg;
            conj2_reg <= conj1_reg;
        end
    end

    // Stage 3: combine sign-extended products into one complex term
    logic signed [OW-1:0] ext [4];
    logic signed [OW-1:0] re_next, im_next;
    logic signed [OW-1:0] re3_reg, im3_reg;
    logic                 v3_reg, last3_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            assign ext[gi] = OW'(prod_reg[gi]);
        end
    endgenerate

    always_comb begin
        if (conj2_reg) begin
            re_next = ext[0] + ext[1];
            im_next = ext[3] - ext[2];
        end else begin
            re_next = ext[0] - ext[1];
            im_next = ext[2] + ext[3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_reg    <= 1'b0;
            last3_reg <= 1'b0;
            re3_reg   <= '0;
            im3_reg   <= '0;
        end else if (adv) begin
            v3_reg    <= v2_reg;
            last3_reg <= last2_reg;
            re3_reg   <= re_next;
            im3_reg   <= im_next;
        end
    end

    // Accumulate / emit; while stalled everything, including the result, holds
    logic signed [OW-1:0] acc_re_reg, acc_im_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re_reg <= '0;
            acc_im_reg <= '0;
            out_re     <= '0;
            out_im     <= '0;
            out_valid  <= 1'b0;
        end else if (adv) begin
            if (v3_reg && last3_reg) begin
                out_re     <= acc_re_reg + re3_reg;
                out_im     <= acc_im_reg + im3_reg;
                out_valid  <= 1'b1;
                acc_re_reg <= '0;
                acc_im_reg <= '0;
            end else begin
                if (v3_reg) begin
                    acc_re_reg <= acc_re_reg + re3_reg;
                    acc_im_reg <= acc_im_reg + im3_reg;
                end
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cplx_mac_pipe.sv
// Directed bench for cplx_mac_pipe: hand-computed results collected on output handshakes.
module tb_cplx_mac_pipe;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int OW = 2*N+1+CW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [N-1:0]  a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic                 conj_b = 1'b0;
    logic [CW-1:0]        acc_len = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_re, out_im;

    int n_checks = 0;
    int n_fail   = 0;

    longint rx_re[$], rx_im[$], ex_re[$], ex_im[$];

    cplx_mac_pipe #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .conj_b(conj_b), .acc_len(acc_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Record every completed output handshake (sampled mid-cycle)
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rx_re.push_back(longint'($signed(out_re)));
            rx_im.push_back(longint'($signed(out_im)));
            $display("rx  re=%0d im=%0d", $signed(out_re), $signed(out_im));
        end
    end

    // Holds the beat until accepted; returns 1 time unit after the accepting edge
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input logic cj, input int len);
        int   guard;
        logic rdy;
        a_re     = ar[N-1:0];
        a_im     = ai[N-1:0];
        b_re     = br[N-1:0];
        b_im     = bi[N-1:0];
        conj_b   = cj;
        acc_len  = len[CW-1:0];
        in_valid = 1'b1;
        guard    = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy)
            chk("send_timeout", 0, 1);
        $display("tx  a=%0d,%0d b=%0d,%0d conj=%0d len=%0d", ar, ai, br, bi, cj, len);
    endtask

    task automatic expect_res(input longint re, input longint im);
        ex_re.push_back(re);
        ex_im.push_back(im);
    endtask

    task automatic drain_and_compare(input string tag);
        int n;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk($sformatf("%s_count", tag), rx_re.size(), ex_re.size());
        n = (rx_re.size() < ex_re.size()) ? rx_re.size() : ex_re.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_re%0d", tag, i), rx_re[i], ex_re[i]);
            chk($sformatf("%s_im%0d", tag, i), rx_im[i], ex_im[i]);
        end
        rx_re.delete(); rx_im.delete(); ex_re.delete(); ex_im.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int g;
        longint hold_re, hold_im;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_re", longint'($signed(out_re)), 0);
        chk("rst_out_im", longint'($signed(out_im)), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic product and its latency
        send(3, 4, 5, 6, 1'b0, 1);
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat == 0)
                lat = k;
        end
        chk("latency", lat, 3);
        expect_res(-9, 38);
        drain_and_compare("basic");

        // Conjugate and extreme operands
        send(3, 4, 5, 6, 1'b1, 1);
        send(-128, -128, -128, -128, 1'b0, 1);
        send(-128, -128, -128, -128, 1'b1, 1);
        expect_res(39, 2);
        expect_res(0, 32768);
        expect_res(32768, 0);
        drain_and_compare("conj_ext");

        // Accumulate 4 (later acc_len changes ignored), then len=1, then mixed-conj len=2
        send(1, 1, 1, 0, 1'b0, 4);
        for (int k = 0; k < 3; k++)
            send(1, 1, 1, 0, 1'b0, 1);
        send(1, 2, 3, 0, 1'b0, 1);
        send(2, 0, 0, 1, 1'b1, 1);
        send(0, 1, 0, 1, 1'b0, 2);
        send(1, 0, 0, 1, 1'b1, 2);
        expect_res(4, 4);
        expect_res(3, 6);
        expect_res(0, -2);
        expect_res(-1, -1);
        drain_and_compare("accum");

        // acc_len=0 means a 16-product frame
        for (int k = 0; k < 16; k++)
            send(1, 0, 1, 0, 1'b0, 0);
        expect_res(16, 0);
        drain_and_compare("len16");

        // Backpressure: out_ready low for 5 cycles while the stream is running
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    send(k, 0, 1, 1, 1'b0, 1);
                in_valid = 1'b0;
            end
            begin
                g = 0;
                while (!out_valid && g < 50) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                chk("bp_first_valid", longint'(out_valid), 1);
                out_ready = 1'b0;
                @(negedge clk);
                chk("bp_in_ready", longint'(in_ready), 0);
                hold_re = longint'($signed(out_re));
                hold_im = longint'($signed(out_im));
                repeat (4) @(negedge clk);
                chk("bp_hold_re", longint'($signed(out_re)), hold_re);
                chk("bp_hold_im", longint'($signed(out_im)), hold_im);
                chk("bp_hold_valid", longint'(out_valid), 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int k = 1; k <= 6; k++)
            expect_res(k, k);
        drain_and_compare("bp");

        // Reset in the middle of a 4-product frame
        send(2, 0, 1, 0, 1'b0, 4);
        send(2, 0, 1, 0, 1'b0, 4);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_re", longint'($signed(out_re)), 0);
        chk("midrst_out_im", longint'($signed(out_im)), 0);
        chk("midrst_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++)
            send(2, 0, 1, 0, 1'b0, 4);
        expect_res(8, 0);
        drain_and_compare("rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
